// File: rtl/rr_otf_converter.sv
// On-the-fly conversion of a radix-R signed-digit MSDF product stream into a
// two's-complement word. Q holds the prefix value and QM holds Q-1; each digit
// picks one of them as the base, shifts it by L bits and fills the low bits.
// No final carry-propagate add is needed.
module rr_otf_converter #(
  parameter int unsigned RADIX   = 4,
  parameter int unsigned NDIGITS = 8,
  localparam int unsigned L = $clog2(RADIX),
  localparam int unsigned D = $clog2(RADIX) + 1,
  localparam int unsigned W = NDIGITS * $clog2(RADIX) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_first,
  input  logic [D-1:0] in_digit,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         digit_err
);

  localparam int unsigned CW = $clog2(NDIGITS + 1);
  // -RADIX is the only encodable illegal digit; it is replaced by -(RADIX-1).
  localparam logic [D-1:0] ILLEGAL   = D'(RADIX);
  localparam logic [D-1:0] MIN_LEGAL = D'(RADIX + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  q_r, qm_r, q_n, qm_n, result_n;
  logic [CW-1:0] cnt, cnt_n, cnt_inc;
  logic          err_n, in_ready_n, out_valid_n;

  logic          accept, start, illegal, dig_pos;
  logic [D-1:0]  dig;
  logic [L-1:0]  fill_q, fill_qm;
  logic [W-1:0]  base_q, base_qm, q_sel, qm_sel, upd_q, upd_qm;

  // Digit datapath: choose bases, then R*base plus low-bit fill.
  always_comb begin
    accept  = in_valid & in_ready;
    start   = in_first | (cnt == '0);
    illegal = (in_digit == ILLEGAL);
    dig     = illegal ? MIN_LEGAL : in_digit;
    dig_pos = !dig[D-1] && (dig != '0);
    // Low L bits of q and q-1 equal the fills for every digit sign.
    fill_q  = dig[L-1:0];
    fill_qm = dig[L-1:0] - L'(1);
    base_q  = start ? '0 : q_r;
    base_qm = start ? '1 : qm_r;
    q_sel   = dig[D-1] ? base_qm : base_q;
    qm_sel  = dig_pos  ? base_q  : base_qm;
    upd_q   = (q_sel  << L) | W'(fill_q);
    upd_qm  = (qm_sel << L) | W'(fill_qm);
    cnt_inc = start ? CW'(1) : cnt + CW'(1);
  end

  // Next-state and next-register values for the accumulate/hold controller.
  always_comb begin
    state_n     = state;
    q_n         = q_r;
    qm_n        = qm_r;
    cnt_n       = cnt;
    result_n    = result;
    err_n       = digit_err;
    in_ready_n  = in_ready;
    out_valid_n = out_valid;
    case (state)
      ACCUM: begin
        if (accept) begin
          q_n   = upd_q;
          qm_n  = upd_qm;
          err_n = start ? illegal : (digit_err | illegal);
          cnt_n = cnt_inc;
          if (cnt_inc == CW'(NDIGITS)) begin
            state_n     = HOLD;
            cnt_n       = '0;
            result_n    = upd_q;
            in_ready_n  = 1'b0;
            out_valid_n = 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_n     = ACCUM;
          q_n         = '0;
          qm_n        = '1;
          err_n       = 1'b0;
          in_ready_n  = 1'b1;
          out_valid_n = 1'b0;
        end
      end
      default: begin
        state_n     = ACCUM;
        in_ready_n  = 1'b1;
        out_valid_n = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      q_r       <= '0;
      qm_r      <= '1;
      cnt       <= '0;
      result    <= '0;
      digit_err <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      q_r       <= q_n;
      qm_r      <= qm_n;
      cnt       <= cnt_n;
      result    <= result_n;
      digit_err <= err_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
    end
  end

endmodule

// File: tb/tb_rr_otf_converter.sv
// Directed bench for rr_otf_converter with RADIX=4, NDIGITS=4 (9-bit result).
module tb_rr_otf_converter;

  localparam int unsigned RADIX   = 4;
  localparam int unsigned NDIGITS = 4;
  localparam int unsigned D       = 3;
  localparam int unsigned W       = 9;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         in_first;
  logic [D-1:0] in_digit;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         digit_err;

  int n_checks;
  int n_fail;
  int hs;

  typedef struct {
    logic [3:0][2:0] d;   // d[3] is the most significant digit
    logic [8:0]      res;
    logic            err;
    string           name;
  } vec_t;

  vec_t vecs[5];

  rr_otf_converter #(.RADIX(RADIX), .NDIGITS(NDIGITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_first  (in_first),
    .in_digit  (in_digit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .digit_err (digit_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count completed output handshakes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs <= 0;
    else if (out_valid && out_ready) hs <= hs + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put_digit(input logic [2:0] d, input logic f, input string name);
    @(negedge clk);
    chk({name, " in_ready"}, 32'(in_ready), 32'd1);
    chk({name, " out_valid low"}, 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_first = f;
    in_digit = d;
  endtask

  // Four consecutive digits; returns at the negedge one cycle after the last accept.
  task automatic send_word(input logic [3:0][2:0] d, input logic f0, input string name);
    for (int i = 0; i < 4; i++) put_digit(d[3-i], (i == 0) ? f0 : 1'b0, name);
    @(negedge clk);
    in_valid = 1'b0;
    in_first = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_first  = 1'b0;
    in_digit  = '0;
    out_ready = 1'b1;

    vecs[0] = '{d: {3'b011, 3'b110, 3'b000, 3'b001}, res: 9'h0A1, err: 1'b0, name: "w_3_m2_0_1"};
    vecs[1] = '{d: {3'b101, 3'b101, 3'b101, 3'b101}, res: 9'h101, err: 1'b0, name: "w_all_m3"};
    vecs[2] = '{d: {3'b000, 3'b000, 3'b000, 3'b000}, res: 9'h000, err: 1'b0, name: "w_zero"};
    vecs[3] = '{d: {3'b001, 3'b100, 3'b000, 3'b000}, res: 9'h010, err: 1'b1, name: "w_illegal"};
    vecs[4] = '{d: {3'b011, 3'b011, 3'b011, 3'b011}, res: 9'h0FF, err: 1'b0, name: "w_all_3"};

    // Reset values.
    repeat (2) @(negedge clk);
    chk("rst in_ready",  32'(in_ready),  32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst result",    32'(result),    32'd0);
    chk("rst digit_err", 32'(digit_err), 32'd0);
    rst_n = 1'b1;

    // Table-driven words, consumer always ready.
    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].d, 1'b1, vecs[v].name);
      chk({vecs[v].name, " out_valid"}, 32'(out_valid), 32'd1);
      chk({vecs[v].name, " result"},    32'(result),    32'(vecs[v].res));
      chk({vecs[v].name, " digit_err"}, 32'(digit_err), 32'(vecs[v].err));
      @(negedge clk);
      chk({vecs[v].name, " out_valid drop"}, 32'(out_valid), 32'd0);
      chk({vecs[v].name, " in_ready back"},  32'(in_ready),  32'd1);
      chk({vecs[v].name, " result kept"},    32'(result),    32'(vecs[v].res));
      chk({vecs[v].name, " err cleared"},    32'(digit_err), 32'd0);
    end

    // Back-pressure: word held while out_ready=0, offered digits ignored.
    out_ready = 1'b0;
    send_word({3'b001, 3'b101, 3'b011, 3'b111}, 1'b1, "hold");
    in_valid = 1'b1;
    in_digit = 3'b011;
    for (int c = 0; c < 5; c++) begin
      chk("hold out_valid", 32'(out_valid), 32'd1);
      chk("hold in_ready",  32'(in_ready),  32'd0);
      chk("hold result",    32'(result),    32'h01B);
      @(negedge clk);
    end
    chk("hold result end", 32'(result), 32'h01B);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("hold out_valid drop", 32'(out_valid), 32'd0);
    chk("hold in_ready back",  32'(in_ready),  32'd1);

    // Mid-word restart: partial word 2,1 discarded.
    begin
      int h0;
      h0 = hs;
      put_digit(3'b010, 1'b1, "restart");
      put_digit(3'b001, 1'b0, "restart");
      send_word({3'b001, 3'b000, 3'b000, 3'b111}, 1'b1, "restart");
      chk("restart out_valid", 32'(out_valid), 32'd1);
      chk("restart result",    32'(result),    32'h03F);
      @(negedge clk);
      chk("restart pulses",    32'(hs - h0),   32'd1);
    end

    // Async reset mid-word, then a word without in_first must start clean.
    put_digit(3'b011, 1'b1, "abort");
    put_digit(3'b011, 1'b0, "abort");
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort result",    32'(result),    32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort in_ready",  32'(in_ready),  32'd1);
    #1 rst_n = 1'b1;
    send_word({3'b000, 3'b000, 3'b000, 3'b010}, 1'b0, "after_rst");
    chk("after_rst out_valid", 32'(out_valid), 32'd1);
    chk("after_rst result",    32'(result),    32'd2);
    chk("after_rst digit_err", 32'(digit_err), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
